// File: rtl/duel_arena.sv
// Two-player lane duel engine: edge-detected moves/fires, fire cooldown, shields, lives, win/restart.
// Optional GALAGA_WRAP_EN: ship positions wrap around the lane edges instead of saturating.
module duel_arena #(
  parameter int unsigned LANES       = 5,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned SHIELD_HITS = 1,
  parameter int unsigned COOLDOWN    = 4,
  localparam int unsigned PW = $clog2(LANES),
  localparam int unsigned LW = $clog2(LIVES + 1),
  localparam int unsigned SW = (SHIELD_HITS > 0) ? $clog2(SHIELD_HITS + 1) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          LEFT,
  input  logic          RIGHT,
  input  logic          LEFT2,
  input  logic          RIGHT2,
  input  logic          DP1,
  input  logic          DP2,
  output logic [PW-1:0] POS1,
  output logic [PW-1:0] POS2,
  output logic [LW-1:0] LIVES1,
  output logic [LW-1:0] LIVES2,
  output logic [SW-1:0] SHIELD1,
  output logic [SW-1:0] SHIELD2,
  output logic          ALIGN,
  output logic          DONE,
  output logic [1:0]    WINNER
);

  localparam logic [PW-1:0] MaxPos     = PW'(LANES - 1);
  localparam logic [LW-1:0] LivesInit  = LW'(LIVES);
  localparam logic [SW-1:0] ShieldInit = SW'(SHIELD_HITS);
  localparam logic [7:0]    CoolInit   = 8'(COOLDOWN);

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  state_e        state_q, state_d;
  logic [6:0]    prev_q, ctrl, evt;
  logic [PW-1:0] pos1_q, pos1_d, pos2_q, pos2_d;
  logic [LW-1:0] lives1_q, lives1_d, lives2_q, lives2_d;
  logic [SW-1:0] shield1_q, shield1_d, shield2_q, shield2_d;
  logic [7:0]    cd1_q, cd1_d, cd2_q, cd2_d;
  logic          align_q, align_d, done_q, done_d;
  logic [1:0]    winner_q, winner_d;
  logic          fire1, fire2, hit1, hit2;

  // Bit order: START, LEFT, RIGHT, LEFT2, RIGHT2, DP1, DP2
  assign ctrl = {START, LEFT, RIGHT, LEFT2, RIGHT2, DP1, DP2};
  assign evt  = ctrl & ~prev_q;

  function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] pos, input logic dec,
                                             input logic inc);
    logic [PW-1:0] res;
    res = pos;
    if (dec && !inc) begin
      if (pos == '0) begin
`ifdef GALAGA_WRAP_EN
        res = MaxPos;
`else
        res = '0;
`endif
      end else begin
        res = pos - 1'b1;
      end
    end else if (inc && !dec) begin
      if (pos == MaxPos) begin
`ifdef GALAGA_WRAP_EN
        res = '0;
`else
        res = MaxPos;
`endif
      end else begin
        res = pos + 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    pos1_d    = pos1_q;
    pos2_d    = pos2_q;
    lives1_d  = lives1_q;
    lives2_d  = lives2_q;
    shield1_d = shield1_q;
    shield2_d = shield2_q;
    cd1_d     = (cd1_q != '0) ? cd1_q - 8'd1 : '0;
    cd2_d     = (cd2_q != '0) ? cd2_q - 8'd1 : '0;
    done_d    = done_q;
    winner_d  = winner_q;
    fire1     = 1'b0;
    fire2     = 1'b0;
    hit1      = 1'b0;
    hit2      = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (evt[6]) begin
          state_d   = StPlay;
          pos1_d    = '0;
          pos2_d    = MaxPos;
          lives1_d  = LivesInit;
          lives2_d  = LivesInit;
          shield1_d = ShieldInit;
          shield2_d = ShieldInit;
          cd1_d     = '0;
          cd2_d     = '0;
          done_d    = 1'b0;
          winner_d  = 2'b00;
        end
      end
      StPlay: begin
        fire1 = evt[1] && (cd1_q == '0);
        fire2 = evt[0] && (cd2_q == '0);
        if (fire1) cd1_d = CoolInit;
        if (fire2) cd2_d = CoolInit;
        // Hits use pre-move positions; simultaneous valid shots cancel
        hit2 = fire1 && !fire2 && (pos1_q == pos2_q);
        hit1 = fire2 && !fire1 && (pos1_q == pos2_q);
        if (hit2) begin
          if (shield2_q != '0)     shield2_d = shield2_q - 1'b1;
          else if (lives2_q != '0) lives2_d  = lives2_q - 1'b1;
        end
        if (hit1) begin
          if (shield1_q != '0)     shield1_d = shield1_q - 1'b1;
          else if (lives1_q != '0) lives1_d  = lives1_q - 1'b1;
        end
        pos1_d = step_pos(pos1_q, evt[5], evt[4]);
        pos2_d = step_pos(pos2_q, evt[3], evt[2]);
        if (lives2_d == '0) begin
          done_d   = 1'b1;
          winner_d = 2'b01;
          state_d  = StOver;
        end else if (lives1_d == '0) begin
          done_d   = 1'b1;
          winner_d = 2'b10;
          state_d  = StOver;
        end
      end
      default: state_d = StIdle;
    endcase

    align_d = (pos1_d == pos2_d);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      prev_q    <= '1;
      pos1_q    <= '0;
      pos2_q    <= MaxPos;
      lives1_q  <= LivesInit;
      lives2_q  <= LivesInit;
      shield1_q <= ShieldInit;
      shield2_q <= ShieldInit;
      cd1_q     <= '0;
      cd2_q     <= '0;
      align_q   <= 1'b0;
      done_q    <= 1'b0;
      winner_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      prev_q    <= ctrl;
      pos1_q    <= pos1_d;
      pos2_q    <= pos2_d;
      lives1_q  <= lives1_d;
      lives2_q  <= lives2_d;
      shield1_q <= shield1_d;
      shield2_q <= shield2_d;
      cd1_q     <= cd1_d;
      cd2_q     <= cd2_d;
      align_q   <= align_d;
      done_q    <= done_d;
      winner_q  <= winner_d;
    end
  end

  assign POS1    = pos1_q;
  assign POS2    = pos2_q;
  assign LIVES1  = lives1_q;
  assign LIVES2  = lives2_q;
  assign SHIELD1 = shield1_q;
  assign SHIELD2 = shield2_q;
  assign ALIGN   = align_q;
  assign DONE    = done_q;
  assign WINNER  = winner_q;

endmodule

// File: tb/tb_duel_arena.sv
// Self-checking bench for duel_arena: a behavioural game model pushes expected outputs per
// cycle into a scoreboard queue, popped and compared one cycle later. Honours GALAGA_WRAP_EN.
module tb_duel_arena;

  localparam int unsigned LANES       = 5;
  localparam int unsigned LIVES       = 3;
  localparam int unsigned SHIELD_HITS = 1;
  localparam int unsigned COOLDOWN    = 4;
  localparam int unsigned PW = $clog2(LANES);
  localparam int unsigned LW = $clog2(LIVES + 1);
  localparam int unsigned SW = (SHIELD_HITS > 0) ? $clog2(SHIELD_HITS + 1) : 1;

  localparam logic [6:0] BtnStart = 7'h40;
  localparam logic [6:0] BtnL1    = 7'h20;
  localparam logic [6:0] BtnR1    = 7'h10;
  localparam logic [6:0] BtnL2    = 7'h08;
  localparam logic [6:0] BtnR2    = 7'h04;
  localparam logic [6:0] BtnF1    = 7'h02;
  localparam logic [6:0] BtnF2    = 7'h01;

  logic          CLK, RST_N, START, LEFT, RIGHT, LEFT2, RIGHT2, DP1, DP2;
  logic [PW-1:0] POS1, POS2;
  logic [LW-1:0] LIVES1, LIVES2;
  logic [SW-1:0] SHIELD1, SHIELD2;
  logic          ALIGN, DONE;
  logic [1:0]    WINNER;

  duel_arena #(
    .LANES      (LANES),
    .LIVES      (LIVES),
    .SHIELD_HITS(SHIELD_HITS),
    .COOLDOWN   (COOLDOWN)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .LEFT   (LEFT),
    .RIGHT  (RIGHT),
    .LEFT2  (LEFT2),
    .RIGHT2 (RIGHT2),
    .DP1    (DP1),
    .DP2    (DP2),
    .POS1   (POS1),
    .POS2   (POS2),
    .LIVES1 (LIVES1),
    .LIVES2 (LIVES2),
    .SHIELD1(SHIELD1),
    .SHIELD2(SHIELD2),
    .ALIGN  (ALIGN),
    .DONE   (DONE),
    .WINNER (WINNER)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int pos1; int pos2; int lives1; int lives2; int sh1; int sh2;
    int align; int done; int winner;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks, n_fail;

  // Game model: 0 idle, 1 play, 2 over
  int         m_st, m_pos1, m_pos2, m_l1, m_l2, m_s1, m_s2, m_cd1, m_cd2;
  int         m_align, m_done, m_win;
  logic [6:0] m_prev;

  function void m_load();
    m_pos1 = 0; m_pos2 = LANES - 1;
    m_l1 = LIVES; m_l2 = LIVES; m_s1 = SHIELD_HITS; m_s2 = SHIELD_HITS;
    m_cd1 = 0; m_cd2 = 0; m_done = 0; m_win = 0; m_align = 0;
  endfunction

  function void m_reset();
    m_load();
    m_st = 0;
    m_prev = 7'h7f;
  endfunction

  function int m_move(input int pos, input bit dec, input bit inc);
    if (dec && !inc) begin
`ifdef GALAGA_WRAP_EN
      return (pos == 0) ? LANES - 1 : pos - 1;
`else
      return (pos == 0) ? 0 : pos - 1;
`endif
    end
    if (inc && !dec) begin
`ifdef GALAGA_WRAP_EN
      return (pos == LANES - 1) ? 0 : pos + 1;
`else
      return (pos == LANES - 1) ? LANES - 1 : pos + 1;
`endif
    end
    return pos;
  endfunction

  function void m_step(input logic [6:0] v);
    logic [6:0] e;
    int c1, c2;
    bit f1, f2, aligned;
    e = v & ~m_prev;
    m_prev = v;
    c1 = m_cd1;
    c2 = m_cd2;
    if (m_cd1 > 0) m_cd1--;
    if (m_cd2 > 0) m_cd2--;
    if (m_st != 1) begin
      if (e[6]) begin
        m_load();
        m_st = 1;
      end
    end else begin
      f1 = e[1] && (c1 == 0);
      f2 = e[0] && (c2 == 0);
      if (f1) m_cd1 = COOLDOWN;
      if (f2) m_cd2 = COOLDOWN;
      aligned = (m_pos1 == m_pos2);
      if (aligned && f1 && !f2) begin
        if (m_s2 > 0) m_s2--;
        else if (m_l2 > 0) m_l2--;
      end
      if (aligned && f2 && !f1) begin
        if (m_s1 > 0) m_s1--;
        else if (m_l1 > 0) m_l1--;
      end
      m_pos1 = m_move(m_pos1, e[5], e[4]);
      m_pos2 = m_move(m_pos2, e[3], e[2]);
      if (m_l2 == 0) begin
        m_done = 1; m_win = 1; m_st = 2;
      end else if (m_l1 == 0) begin
        m_done = 1; m_win = 2; m_st = 2;
      end
    end
    m_align = (m_pos1 == m_pos2) ? 1 : 0;
  endfunction

  function exp_t m_snap();
    exp_t s;
    s = '{m_pos1, m_pos2, m_l1, m_l2, m_s1, m_s2, m_align, m_done, m_win};
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    check_eq("POS1", 32'(POS1), e.pos1);
    check_eq("POS2", 32'(POS2), e.pos2);
    check_eq("LIVES1", 32'(LIVES1), e.lives1);
    check_eq("LIVES2", 32'(LIVES2), e.lives2);
    check_eq("SHIELD1", 32'(SHIELD1), e.sh1);
    check_eq("SHIELD2", 32'(SHIELD2), e.sh2);
    check_eq("ALIGN", 32'(ALIGN), e.align);
    check_eq("DONE", 32'(DONE), e.done);
    check_eq("WINNER", 32'(WINNER), e.winner);
  endtask

  task automatic drive(input logic [6:0] v);
    {START, LEFT, RIGHT, LEFT2, RIGHT2, DP1, DP2} = v;
  endtask

  task automatic cycle(input logic [6:0] v);
    drive(v);
    m_step(v);
    sb_q.push_back(m_snap());
    @(posedge CLK);
    #1;
    compare(sb_q.pop_front());
  endtask

  task automatic pulse(input logic [6:0] v);
    cycle(v);
    cycle(7'h00);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST_N    = 1'b1;
    // START and LEFT held through reset must not count as edges
    drive(BtnStart | BtnL1);
    #1;
    RST_N = 1'b0;
    m_reset();
    #2;
    compare(m_snap());
    @(negedge CLK);
    RST_N = 1'b1;
    cycle(BtnStart | BtnL1);
    cycle(BtnStart | BtnR1);
    cycle(7'h00);
    cycle(BtnStart);
    cycle(7'h00);

    repeat (5) pulse(BtnR1);
`ifdef GALAGA_WRAP_EN
    pulse(BtnL1);
`endif

    // Shield hit, cooldown-blocked shot, then life hit
    cycle(BtnF1);
    cycle(7'h00);
    cycle(BtnF1);
    repeat (3) cycle(7'h00);
    cycle(BtnF1);
    repeat (5) cycle(7'h00);

    // Simultaneous shots cancel; P2's follow-up blocked by cooldown
    cycle(BtnF1 | BtnF2);
    cycle(7'h00);
    cycle(BtnF2);
    repeat (5) cycle(7'h00);

    repeat (2) begin
      cycle(BtnF1);
      repeat (5) cycle(7'h00);
    end
    pulse(BtnL1);
    pulse(BtnF2);
    pulse(BtnF1);

    // Restart; P2 wins this round
    pulse(BtnStart);
    cycle(BtnL1 | BtnR1);
    cycle(7'h00);
    repeat (4) pulse(BtnL2);
    repeat (4) begin
      cycle(BtnF2);
      repeat (5) cycle(7'h00);
    end
    pulse(BtnR2);

    // Async reset mid-cooldown, between clock edges
    pulse(BtnStart);
    pulse(BtnR1);
    cycle(BtnF1);
    #3;
    RST_N = 1'b0;
    m_reset();
    #1;
    compare(m_snap());
    @(negedge CLK);
    RST_N = 1'b1;
    pulse(BtnR1);
    pulse(BtnStart);
    pulse(BtnR1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
